// File: rtl/text_video_generator.sv
// rtl/text_video_generator.sv - parametrised text-mode video timing, addressing and pixel pipeline
// Attributes, cursor styles and circular-row scroll; outputs aligned 3 pixel ticks after the counters.
module text_video_generator #(
    parameter int H_VISIBLE    = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int SYNC_POL     = 0,
    parameter int COLS         = 80,
    parameter int ROWS         = 24,
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 16,
    parameter int COL_BITS     = 7,
    parameter int ROW_BITS     = 5,
    parameter int ADDR_BITS    = 11,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ce_pixel,
    output logic                           hsync,
    output logic                           vsync,
    output logic                           hblank,
    output logic                           vblank,
    output logic                           video,
    input  logic [COL_BITS-1:0]            cursor_x,
    input  logic [ROW_BITS-1:0]            cursor_y,
    input  logic [1:0]                     cursor_mode,
    input  logic [ROW_BITS-1:0]            scroll_row,
    output logic [ADDR_BITS-1:0]           char_buffer_address,
    input  logic [7:0]                     char_buffer_data,
    input  logic [2:0]                     attr_data,
    output logic [8+$clog2(CHAR_H)-1:0]    char_rom_address,
    input  logic [7:0]                     char_rom_data
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HOFF    = (H_VISIBLE - COLS * CHAR_W) / 2;
    localparam int VOFF    = (V_VISIBLE - ROWS * CHAR_H) / 2;
    localparam int HC_BITS = $clog2(H_TOTAL);
    localparam int VC_BITS = $clog2(V_TOTAL);
    localparam int CW_BITS = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
    localparam int CH_BITS = $clog2(CHAR_H);
    localparam int FC_BITS = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [HC_BITS-1:0]  HC_LAST       = HC_BITS'(H_TOTAL - 1);
    localparam logic [HC_BITS-1:0]  HC_WIN_START  = HC_BITS'(HOFF);
    localparam logic [HC_BITS-1:0]  HC_WIN_W      = HC_BITS'(COLS * CHAR_W);
    localparam logic [HC_BITS-1:0]  HC_VIS        = HC_BITS'(H_VISIBLE);
    localparam logic [HC_BITS-1:0]  HC_SYNC_START = HC_BITS'(H_VISIBLE + H_FP);
    localparam logic [HC_BITS-1:0]  HC_SYNC_W     = HC_BITS'(H_SYNC);
    localparam logic [VC_BITS-1:0]  VC_LAST       = VC_BITS'(V_TOTAL - 1);
    localparam logic [VC_BITS-1:0]  VC_WIN_START  = VC_BITS'(VOFF);
    localparam logic [VC_BITS-1:0]  VC_WIN_W      = VC_BITS'(ROWS * CHAR_H);
    localparam logic [VC_BITS-1:0]  VC_VIS        = VC_BITS'(V_VISIBLE);
    localparam logic [VC_BITS-1:0]  VC_SYNC_START = VC_BITS'(V_VISIBLE + V_FP);
    localparam logic [VC_BITS-1:0]  VC_SYNC_W     = VC_BITS'(V_SYNC);
    localparam logic [CW_BITS-1:0]  CW_LAST       = CW_BITS'(CHAR_W - 1);
    localparam logic [CH_BITS-1:0]  CH_LAST       = CH_BITS'(CHAR_H - 1);
    localparam logic [CH_BITS-1:0]  CH_UL         = CH_BITS'(CHAR_H - 2);
    localparam logic [COL_BITS-1:0] COL_LAST      = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST      = ROW_BITS'(ROWS - 1);
    localparam logic [ROW_BITS:0]   ROWS_EXT      = (ROW_BITS + 1)'(ROWS);
    localparam logic [FC_BITS-1:0]  FC_LAST       = FC_BITS'(BLINK_FRAMES - 1);
    localparam logic                SYNC_ON       = 1'(SYNC_POL);

    if (COLS * CHAR_W > H_VISIBLE || ROWS * CHAR_H > V_VISIBLE) begin : g_bad_window
        $error("text window does not fit in the visible area");
    end
    if (CHAR_W < 1 || CHAR_W > 8 || CHAR_H < 2 || (1 << CH_BITS) != CHAR_H) begin : g_bad_cell
        $error("unsupported character cell size");
    end

    logic [HC_BITS-1:0]  hc, hc_next, hrel, hsrel;
    logic [VC_BITS-1:0]  vc, vc_next, vrel, vsrel;
    logic [CW_BITS-1:0]  colc;
    logic [COL_BITS-1:0] col;
    logic [CH_BITS-1:0]  rowc;
    logic [ROW_BITS-1:0] row;
    logic [FC_BITS-1:0]  frame_cnt;
    logic                blink_phase;

    logic [ROW_BITS-1:0] scroll_q, cur_y_q;
    logic [COL_BITS-1:0] cur_x_q;
    logic [1:0]          mode_q;
    logic                frame_start;
    logic [ROW_BITS-1:0] scroll_now, scroll_eff, cur_y_eff;
    logic [COL_BITS-1:0] cur_x_eff;
    logic [1:0]          mode_eff;
    logic [ROW_BITS:0]   prow_sum, prow_w;

    logic                win0, hs0, vs0, hde0, vde0, cur_hit0, cur_inv0;

    assign hc_next = (hc == HC_LAST) ? '0 : hc + 1'b1;
    assign vc_next = (vc == VC_LAST) ? '0 : vc + 1'b1;
    assign hrel    = hc - HC_WIN_START;
    assign vrel    = vc - VC_WIN_START;
    assign hsrel   = hc - HC_SYNC_START;
    assign vsrel   = vc - VC_SYNC_START;

    assign win0 = (hrel < HC_WIN_W) && (vrel < VC_WIN_W);
    assign hs0  = hsrel < HC_SYNC_W;
    assign vs0  = vsrel < VC_SYNC_W;
    assign hde0 = hc < HC_VIS;
    assign vde0 = vc < VC_VIS;

    // Frame-start tick uses the live inputs so the new frame's first line already sees them.
    assign frame_start = (hc == '0) && (vc == '0);
    assign scroll_now  = ROW_BITS'(scroll_row % ROWS);
    assign scroll_eff  = frame_start ? scroll_now  : scroll_q;
    assign cur_x_eff   = frame_start ? cursor_x    : cur_x_q;
    assign cur_y_eff   = frame_start ? cursor_y    : cur_y_q;
    assign mode_eff    = frame_start ? cursor_mode : mode_q;

    // row saturates at ROWS-1 and scroll is pre-reduced, so one conditional subtract suffices.
    assign prow_sum = {1'b0, row} + {1'b0, scroll_eff};
    assign prow_w   = (prow_sum >= ROWS_EXT) ? prow_sum - ROWS_EXT : prow_sum;
    assign char_buffer_address = ADDR_BITS'(prow_w[ROW_BITS-1:0]) * ADDR_BITS'(COLS)
                               + ADDR_BITS'(col);

    assign cur_hit0 = win0 && (row == cur_y_eff) && (col == cur_x_eff);

    always_comb begin
        cur_inv0 = 1'b0;
        case (mode_eff)
            2'b01:   cur_inv0 = cur_hit0;
            2'b10:   cur_inv0 = cur_hit0 && blink_phase;
            2'b11:   cur_inv0 = cur_hit0 && blink_phase && (rowc >= CH_UL);
            default: cur_inv0 = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hc          <= '0;
            vc          <= '0;
            colc        <= '0;
            col         <= '0;
            rowc        <= '0;
            row         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            scroll_q    <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            mode_q      <= '0;
        end else if (ce_pixel) begin
            hc <= hc_next;
            if (frame_start) begin
                scroll_q <= scroll_now;
                cur_x_q  <= cursor_x;
                cur_y_q  <= cursor_y;
                mode_q   <= cursor_mode;
            end
            if (hc_next == HC_WIN_START) begin
                colc <= '0;
                col  <= '0;
            end else if (colc == CW_LAST) begin
                colc <= '0;
                if (col != COL_LAST) col <= col + 1'b1;
            end else begin
                colc <= colc + 1'b1;
            end
            if (hc == HC_LAST) begin
                vc <= vc_next;
                if (vc_next == VC_WIN_START) begin
                    rowc <= '0;
                    row  <= '0;
                end else begin
                    rowc <= rowc + 1'b1;
                    if (rowc == CH_LAST && row != ROW_LAST) row <= row + 1'b1;
                end
                if (vc == VC_LAST) begin
                    if (frame_cnt == FC_LAST) begin
                        frame_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Stage 1 lines up with the buffer read, stage 2 with the glyph row; sync/blank carried as active flags.
    logic                win1, hs1, vs1, hde1, vde1, cur1;
    logic                win2, hs2, vs2, hde2, vde2, cur2;
    logic [CW_BITS-1:0]  colc1, colc2;
    logic [CH_BITS-1:0]  rowc1, rowc2;
    logic [2:0]          attr2;
    logic [2:0]          bit_idx;
    logic                pix;

    assign char_rom_address = {char_buffer_data, rowc1};
    assign bit_idx          = 3'd7 - 3'(colc2);

    always_comb begin
        pix = char_rom_data[bit_idx];
        if (attr2[1] && rowc2 == CH_LAST) pix = 1'b1;
        if (attr2[2] && !blink_phase)     pix = 1'b0;
        if (attr2[0])                     pix = ~pix;
        if (cur2)                         pix = ~pix;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {win1, hs1, vs1, hde1, vde1, cur1} <= '0;
            {win2, hs2, vs2, hde2, vde2, cur2} <= '0;
            colc1  <= '0;
            colc2  <= '0;
            rowc1  <= '0;
            rowc2  <= '0;
            attr2  <= '0;
            hsync  <= ~SYNC_ON;
            vsync  <= ~SYNC_ON;
            hblank <= 1'b1;
            vblank <= 1'b1;
            video  <= 1'b0;
        end else if (ce_pixel) begin
            {win1, hs1, vs1, hde1, vde1, cur1} <= {win0, hs0, vs0, hde0, vde0, cur_inv0};
            {win2, hs2, vs2, hde2, vde2, cur2} <= {win1, hs1, vs1, hde1, vde1, cur1};
            colc1  <= colc;
            colc2  <= colc1;
            rowc1  <= rowc;
            rowc2  <= rowc1;
            attr2  <= attr_data;
            hsync  <= hs2 ? SYNC_ON : ~SYNC_ON;
            vsync  <= vs2 ? SYNC_ON : ~SYNC_ON;
            hblank <= ~hde2;
            vblank <= ~vde2;
            video  <= win2 && hde2 && vde2 && pix;
        end
    end

endmodule

// File: tb/tb_text_video_generator.sv
// tb/tb_text_video_generator.sv - directed self-checking bench for text_video_generator
// Small 44x26 timing with a 3x3 grid of 8x4 cells keeps each frame at 1144 ticks.
module tb_text_video_generator;

    localparam int HV = 32, HFP = 4, HS = 4, HBP = 4, HT = 44;
    localparam int VV = 20, VFP = 2, VS = 2, VBP = 2, VT = 26;
    localparam int FT = HT * VT;
    localparam int NCOLS = 3, NROWS = 3, CW = 8, CH = 4, HOFF = 4, VOFF = 4, BF = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce_pixel = 1'b1;
    logic       hsync, vsync, hblank, vblank, video;
    logic [1:0] cursor_x = 2'd2;
    logic [1:0] cursor_y = 2'd1;
    logic [1:0] cursor_mode = 2'd0;
    logic [1:0] scroll_row = 2'd0;
    logic [3:0] char_buffer_address;
    logic [7:0] char_buffer_data;
    logic [2:0] attr_data;
    logic [9:0] char_rom_address;
    logic [7:0] char_rom_data;

    logic [7:0] rom_val = 8'h00;
    logic [2:0] attr_val = 3'b000;
    logic [7:0] buf_q = 8'h00;
    logic [2:0] attr_q = 3'b000;
    logic [7:0] rom_q = 8'h00;

    text_video_generator #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(0), .COLS(NCOLS), .ROWS(NROWS), .CHAR_W(CW), .CHAR_H(CH),
        .COL_BITS(2), .ROW_BITS(2), .ADDR_BITS(4), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset), .ce_pixel(ce_pixel),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank), .video(video),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_mode(cursor_mode),
        .scroll_row(scroll_row),
        .char_buffer_address(char_buffer_address), .char_buffer_data(char_buffer_data),
        .attr_data(attr_data),
        .char_rom_address(char_rom_address), .char_rom_data(char_rom_data)
    );

    always #5 clk = ~clk;

    // Character buffer returns its address as the code; the font ROM returns a fixed row.
    always @(posedge clk) begin
        buf_q  <= 8'(char_buffer_address);
        attr_q <= attr_val;
        rom_q  <= rom_val;
    end
    assign char_buffer_data = buf_q;
    assign attr_data        = attr_q;
    assign char_rom_data    = rom_q;

    int total = 0;
    int bad = 0;
    int n = 0;
    int scan_bad, hs_cnt, hb_cnt, vs_cnt, vb_cnt;
    int lit_cnt [0:7];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        n++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ce_pixel = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
    endtask

    task automatic goto(input int target);
        while (n < target) tick();
    endtask

    function automatic logic exp_video(input int p);
        int hc, vc, col, colc, row, rowc, phase;
        logic g;
        hc = p % HT;
        vc = (p / HT) % VT;
        if (hc < HOFF || hc >= HOFF + NCOLS * CW || vc < VOFF || vc >= VOFF + NROWS * CH)
            return 1'b0;
        col   = (hc - HOFF) / CW;
        colc  = (hc - HOFF) % CW;
        row   = (vc - VOFF) / CH;
        rowc  = (vc - VOFF) % CH;
        phase = ((p / FT) / BF) % 2;
        g = rom_val[7 - colc];
        if (attr_val[1] && rowc == CH - 1) g = 1'b1;
        if (attr_val[2] && phase == 0)     g = 1'b0;
        if (attr_val[0])                   g = ~g;
        if (row == int'(cursor_y) && col == int'(cursor_x)) begin
            case (cursor_mode)
                2'd1: g = ~g;
                2'd2: if (phase == 1) g = ~g;
                2'd3: if (phase == 1 && rowc >= CH - 2) g = ~g;
                default: ;
            endcase
        end
        return g;
    endfunction

    task automatic scan(input int nframes);
        int p, hc, vc;
        scan_bad = 0; hs_cnt = 0; hb_cnt = 0; vs_cnt = 0; vb_cnt = 0;
        for (int i = 0; i < 8; i++) lit_cnt[i] = 0;
        for (int k = 0; k < nframes * FT + 3; k++) begin
            if (n >= 3) begin
                p  = n - 3;
                hc = p % HT;
                vc = (p / HT) % VT;
                if (video !== exp_video(p)) scan_bad++;
                if (hsync !== ((hc >= HV + HFP && hc < HV + HFP + HS) ? 1'b0 : 1'b1)) scan_bad++;
                if (vsync !== ((vc >= VV + VFP && vc < VV + VFP + VS) ? 1'b0 : 1'b1)) scan_bad++;
                if (hblank !== (hc >= HV)) scan_bad++;
                if (vblank !== (vc >= VV)) scan_bad++;
                if (hsync === 1'b0) hs_cnt++;
                if (vsync === 1'b0) vs_cnt++;
                if (hblank === 1'b1) hb_cnt++;
                if (vblank === 1'b1) vb_cnt++;
                if (video === 1'b1) lit_cnt[p / FT]++;
            end
            tick();
        end
    endtask

    int exp_cur [0:3][0:3] = '{'{0, 0, 0, 0}, '{32, 32, 32, 32}, '{0, 0, 32, 32}, '{0, 0, 16, 16}};
    logic v_hold;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, sync timing and first-pixel-of-cell glyph
        rom_val = 8'h80; attr_val = 3'b000; scroll_row = 2'd0; cursor_mode = 2'd0;
        do_reset();
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_hblank", hblank, 1);
        check("rst_vblank", vblank, 1);
        check("rst_video", video, 0);
        check("rst_addr", char_buffer_address, 0);
        scan(2);
        check("scan_080", scan_bad, 0);
        check("lit_080_f0", lit_cnt[0], 36);
        check("lit_080_f1", lit_cnt[1], 36);
        check("hsync_ticks", hs_cnt, 208);
        check("hblank_ticks", hb_cnt, 624);
        check("vsync_ticks", vs_cnt, 176);
        check("vblank_ticks", vb_cnt, 528);

        rom_val = 8'h00; attr_val = 3'b001;
        do_reset(); scan(1);
        check("scan_reverse", scan_bad, 0);
        check("lit_reverse", lit_cnt[0], 288);

        attr_val = 3'b010;
        do_reset(); scan(1);
        check("scan_underline", scan_bad, 0);
        check("lit_underline", lit_cnt[0], 72);

        rom_val = 8'hFF; attr_val = 3'b100;
        do_reset(); scan(4);
        check("scan_blink", scan_bad, 0);
        check("lit_blink_f0", lit_cnt[0], 0);
        check("lit_blink_f1", lit_cnt[1], 0);
        check("lit_blink_f2", lit_cnt[2], 288);
        check("lit_blink_f3", lit_cnt[3], 288);

        rom_val = 8'h00; attr_val = 3'b000;
        for (int m = 0; m < 4; m++) begin
            cursor_mode = 2'(m);
            do_reset(); scan(4);
            check($sformatf("scan_cursor_m%0d", m), scan_bad, 0);
            for (int f = 0; f < 4; f++)
                check($sformatf("lit_cursor_m%0d_f%0d", m, f), lit_cnt[f], exp_cur[m][f]);
        end

        // Addressing, scroll sampling and clock-enable hold
        cursor_mode = 2'd0; scroll_row = 2'd0;
        do_reset();
        goto(4 * HT + 4);   check("addr_r0c0", char_buffer_address, 0);
        goto(4 * HT + 12);  check("addr_r0c1", char_buffer_address, 1);
        goto(4 * HT + 13);  check("rom_addr_c1", char_rom_address, 4);
        goto(4 * HT + 27);  check("addr_r0c2_last", char_buffer_address, 2);
        goto(8 * HT + 4);   check("addr_r1c0", char_buffer_address, 3);
        v_hold = video;
        ce_pixel = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("ce_hold_addr", char_buffer_address, 3);
        check("ce_hold_video", video, v_hold);
        ce_pixel = 1'b1;
        goto(9 * HT + 5);   check("rom_addr_r1", char_rom_address, 13);
        goto(12 * HT + 4);  check("addr_r2c0", char_buffer_address, 6);
        goto(13 * HT);      scroll_row = 2'd2;
        goto(14 * HT + 4);  check("scroll_midframe", char_buffer_address, 6);
        goto(FT + 4 * HT + 4);  check("scroll2_r0", char_buffer_address, 6);
        goto(FT + 8 * HT + 4);  check("scroll2_r1", char_buffer_address, 0);
        goto(FT + 12 * HT + 4); check("scroll2_r2", char_buffer_address, 3);
        scroll_row = 2'd3;
        goto(2 * FT + 4 * HT + 4); check("scroll3_r0", char_buffer_address, 0);
        goto(2 * FT + 8 * HT + 4); check("scroll3_r1", char_buffer_address, 3);

        // Mid-frame reset and sync edge positions after release
        scroll_row = 2'd0; rom_val = 8'hFF;
        do_reset();
        goto(10 * HT + 10); check("pre_reset_video", video, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_video", video, 0);
        check("mid_rst_hblank", hblank, 1);
        check("mid_rst_vblank", vblank, 1);
        check("mid_rst_hsync", hsync, 1);
        check("mid_rst_vsync", vsync, 1);
        reset = 1'b0;
        n = 0;
        goto(HV + HFP + 2); check("hsync_before_edge", hsync, 1);
        goto(HV + HFP + 3); check("hsync_edge", hsync, 0);
        goto((VV + VFP) * HT + 2); check("vsync_before_edge", vsync, 1);
        goto((VV + VFP) * HT + 3); check("vsync_edge", vsync, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/text_video_generator.md
Name: text_video_generator

Overview:
- Parametrised successor to the fixed 640x480 VT52 text video generator.
- Programmable sync timing, character cell size and text-window centring.
- Adds per-character attributes (reverse, underline, blink), cursor modes and hardware scroll via a circular row offset.
- Sits between the character buffer / font ROM and the video output stage.
- Produces sync, blank and a 1-bit pixel stream, pipelined to stay mutually aligned.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch
- SYNC_POL, 0, active sync level (both syncs)
- COLS, 80, text columns
- ROWS, 24, text rows
- CHAR_W, 8, cell width, 1..8
- CHAR_H, 16, cell height, power of 2
- COL_BITS, 7, width of column indices
- ROW_BITS, 5, width of row indices
- ADDR_BITS, 11, char buffer address width
- BLINK_FRAMES, 32, frames per blink half-period

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce_pixel  in  1  pixel clock enable
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- hblank  out  1  horizontal blank
- vblank  out  1  vertical blank
- video  out  1  pixel
- cursor_x  in  COL_BITS  cursor column
- cursor_y  in  ROW_BITS  cursor row (logical, pre-scroll)
- cursor_mode  in  2  cursor style: 00 off, 01 steady block, 10 blinking block, 11 blinking underline
- scroll_row  in  ROW_BITS  physical buffer row shown at top of screen
- char_buffer_address  out  ADDR_BITS  character buffer read address
- char_buffer_data  in  8  character code, one-clk synchronous read
- attr_data  in  3  attributes, returned with char_buffer_data: bit0 reverse, bit1 underline, bit2 blink
- char_rom_address  out  8+log2(CHAR_H)  {char, rowc}
- char_rom_data  in  8  glyph row, MSB is leftmost pixel

Behaviour:
- Single clock domain; one clock, reset synchronous and active-high.
- All state advances only when ce_pixel=1, except reset.
- Reset values: hsync=vsync=~SYNC_POL, hblank=vblank=1, video=0; counters, pipeline, frame counter and blink_phase = 0.
- Reset asserted mid-frame takes effect on the next clk edge; the frame restarts at hc=vc=0.
- Line order: visible, FP, sync, BP. Totals are H_VISIBLE+H_FP+H_SYNC+H_BP and V_VISIBLE+V_FP+V_SYNC+V_BP.
- hc wraps to 0 at the line total; vc increments on hc wrap and wraps at the frame total.
- Text window is centred: HOFF=(H_VISIBLE-COLS*CHAR_W)/2, VOFF=(V_VISIBLE-ROWS*CHAR_H)/2.
- Elaboration fails if COLS*CHAR_W>H_VISIBLE or ROWS*CHAR_H>V_VISIBLE.
- Inside the window: col=(hc-HOFF)/CHAR_W, colc=(hc-HOFF)%CHAR_W, row=(vc-VOFF)/CHAR_H, rowc=(vc-VOFF)%CHAR_H. Counters are incremental; no dividers.
- Physical row prow=(row+scroll_row) mod ROWS. The result must never exceed ROWS-1, including when scroll_row>=ROWS (taken mod ROWS).
- scroll_row, cursor_mode and cursor position are sampled once per frame at hc=vc=0. Mid-frame changes take effect next frame.
- char_buffer_address=prow*COLS+col.
- Pipeline, in ce ticks:
  - S0: counters and address.
  - S1: char/attr registered; char_rom_address driven from it.
  - S2: glyph row registered.
  - S3: output registers.
- sync/blank/window/colc/rowc/attr/cursor flags are delayed to match, so every output is exactly 3 ticks after its S0 position.
- Pixel at S3:
  - g=char_rom_data[7-colc]
  - if underline attr and rowc==CHAR_H-1 then g=1
  - if blink attr and blink_phase==0 then g=0
  - if reverse then g=~g
- Cursor hit when row==cursor_y and col==cursor_x (logical row):
  - mode 01: invert.
  - mode 10: invert when blink_phase=1.
  - mode 11: invert when blink_phase=1 and rowc>=CHAR_H-2.
  - mode 00: no effect.
- video=0 whenever blanked or outside the text window.
- Frame counter increments at each vc wrap. At BLINK_FRAMES-1 it clears and blink_phase toggles.

Test Plan:
- Defaults, free-run 2 frames:
  - hsync at SYNC_POL for 96 of every 800 ticks; hblank high 160 of 800.
  - vsync active 2 of 525 lines; vblank high 45 lines.
  - Edges 3 ticks after the S0 positions hc=656 and vc=490.
- Addressing, scroll_row=0:
  - at vc=48: address 0 at hc=0, 1 at hc=8, 79 at hc=632.
  - at vc=64,hc=0: address 80.
  - With scroll_row=23: vc=48 gives 1840, vc=64 gives 0.
- ROM always 0x80, attr=0: video=1 on the first pixel of each cell only, lines 48..431; 0 elsewhere.
- ROM=0x00:
  - attr=001: all 8 pixels of every cell are 1.
  - attr=010: only rowc=15 lines are 1.
  - attr=100 with ROM=0xFF, BLINK_FRAMES=2: cell lit 2 frames, dark 2 frames.
- Cursor (5,2), ROM=0, BLINK_FRAMES=2:
  - mode 01: cell lit every frame.
  - mode 10: cell lit on alternate 2-frame periods.
  - mode 11: only rowc 14..15 lit, alternating.
  - mode 00: cell dark.
- Assert reset for 1 clk at vc=200:
  - next clk: video=0, hblank=vblank=1, syncs inactive.
  - After release, first hsync edge at the normal position relative to hc=0.
